ctdsm_cic_decimator: RTL and testbench
======================================

# ctdsm_cic_decimator

Digital back end of the first-order continuous-time delta-sigma modulator. It takes the modulator's 1-bit comparator bitstream, one bit per `en` strobe, and runs it through a second-order CIC (sinc²) decimation filter with ratio R = 2^RATE_LOG2. It delivers multi-bit PCM samples through a one-deep valid/ready output buffer with a sticky overrun flag, and sits between the modulator's digital output and the project's output/readout logic.

## Interface
- `RATE_LOG2`, default 5, log2 of decimation ratio R (legal 2..7; R=32 by default)
- `DW`, default 2*RATE_LOG2+1, output/internal datapath width (derived, not overridden)
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset
- `en`  in  1  bitstream sample strobe; `bit_in` consumed on edges where `en`=1
- `bit_in`  in  1  modulator bit (1 = +full scale, 0 = −full scale)
- `out_data`  out  DW  decimated sample (unsigned, or two's complement with offset macro)
- `out_valid`  out  1  `out_data` holds an unconsumed sample
- `out_ready`  in  1  consumer accepts sample on edge where `out_valid`&&`out_ready`
- `overrun`  out  1  sticky: an unconsumed sample was overwritten

## Operation
- All arithmetic is DW bits and wraps mod 2^DW; CIC correctness relies on the wrap, so no saturation anywhere.
- Integrators update on `en`=1 edges only, registered form: I1' = I1 + bit_in; I2' = I2 + I1 (old I1).
- Sample counter `cnt` (RATE_LOG2 bits) increments on each `en` edge and wraps R−1→0. A `en` edge with `cnt`==R−1 is the decimation edge and sets internal `dec_pend`.
- Comb, on the edge after a decimation edge: C1 = I2 − I2_d; C2 = C1 − C1_d; I2_d ← I2; C1_d ← C1; output buffer ← C2.
- Constant input 1 gives steady output R² (1024 at R=32). Constant 0 gives 0.
- Output buffer:
  - Load sets `out_valid`.
  - An accept (valid&&ready) with no simultaneous load clears `out_valid`.
  - A load on the same edge as an accept keeps `out_valid`=1 with the new data, and does not set `overrun`.
  - A load while `out_valid`=1 and `out_ready`=0 overwrites the data and sets `overrun`.
- `overrun` clears only on `rst`.
- `en` may be any duty cycle, including every clock; `out_ready` is independent of `en`.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `overrun`=0; I1, I2, I2_d, C1_d, `cnt`, `dec_pend` all 0.
- `rst` has priority over `en`/`out_ready` on the same edge. Reset mid-frame discards the partial frame, and the pending output is lost.
- Latency: `out_valid` rises on the first edge after the decimation edge, i.e. 1 clk after the R-th bit is consumed, regardless of `en` in that cycle.
- A decimation edge can occur at most every R clocks, so the comb path never sees back-to-back loads.
- First outputs after reset with all-ones input, R=32: 496, then 1024, 1024, … (filter warm-up; two outputs to settle).
- `out_data` is stable while `out_valid`=1 and no load occurs.

## Configuration
- `CTDSM_DEC_OFFSET_EN` defined:
  - Comb result minus R²/2 (constant 512 at R=32) before loading; `out_data` is two's complement, range −R²/2..+R²/2.
  - All ones → +512, all zeros → −512, 50% density → 0.
- Undefined: raw unsigned C2, range 0..R²; all ones → 1024, zeros → 0, 50% → 512.
- Handshake, latency and overrun are identical in both builds.

## Structure
- `ctdsm_pkg`:
  - `CTDSM_RATE_LOG2_DEF` (=5)
  - function `ctdsm_dw(rate_log2)` returning 2*rate_log2+1
  - `ctdsm_sample_t` typedef for the default width
  - offset constant R²/2 as a function of rate_log2
- One sub-module, `ctdsm_cic_comb`: a DW-bit single comb stage (in, load strobe, delayed register, difference out), instantiated twice.
- Integrators, counter and output buffer stay in the top.

## Test plan
- Reset, then 5 frames (160 `en` edges, `en`=1 every clk) of bit_in=1, `out_ready`=1 → outputs 496, 1024, 1024, 1024, 1024. Each `out_valid` rises 1 clk after the 32nd bit of its frame; `overrun`=0. With `CTDSM_DEC_OFFSET_EN`: −16, 512, 512, 512, 512.
- Alternating 1,0,… from reset, `en` every 3rd clk → settled outputs 512 (0 with offset). Output spacing is 96 clks.
- All-zeros input → every output 0 (−512 with offset); `out_valid` pulses once per frame with `out_ready`=1.
- `out_ready`=0 across two decimation events → second load sets `overrun`=1 and `out_data` shows the newer sample. `overrun` stays 1 after `out_ready` returns, until `rst`.
- `out_ready`=1 asserted on exactly the load edge while `out_valid`=1 → `out_valid` stays 1 with new data and `overrun` stays 0.
- Assert `rst` at bit 20 of a frame with `out_valid`=1 → next edge all outputs 0. The next output comes 32 `en` edges (+1 clk) after `rst` drops and equals the warm-up value 496 for all-ones.

Source files
------------

// File: rtl/ctdsm_cic_decimator_pkg.sv
// ctdsm_pkg: shared constants and helpers for the CT delta-sigma decimator.
// Provides default rate, datapath width function, sample type, and offset.
package ctdsm_pkg;

   localparam int CTDSM_RATE_LOG2_DEF = 5;

   function automatic int ctdsm_dw(input int rate_log2);
      return 2 * rate_log2 + 1;
   endfunction

   localparam int CTDSM_DW_DEF = ctdsm_dw(CTDSM_RATE_LOG2_DEF);

   typedef logic [CTDSM_DW_DEF-1:0] ctdsm_sample_t;

   // Mid-scale of the sinc^2 output range, R^2/2.
   function automatic int ctdsm_offset(input int rate_log2);
      return 1 << (2 * rate_log2 - 1);
   endfunction

endpackage

// File: rtl/ctdsm_cic_decimator_if.sv
// ctdsm_cic_decimator_if: PCM output stream (valid/ready plus overrun flag).
// master drives out_data/out_valid/overrun; slave drives out_ready.
interface ctdsm_cic_decimator_if
   import ctdsm_pkg::*;
#(
   parameter int DW = CTDSM_DW_DEF
) ();

   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          overrun;

   modport master (
      output out_data,
      output out_valid,
      output overrun,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  overrun,
      output out_ready
   );

endinterface

// File: rtl/ctdsm_cic_decimator_comb.sv
// ctdsm_cic_comb: one CIC comb stage, y = x - x_delayed.
// Ports: clk, rst (sync, active-high), load (capture x), x in, y out.
module ctdsm_cic_comb
   import ctdsm_pkg::*;
#(
   parameter int DW = CTDSM_DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] x,
   output logic [DW-1:0] y
);

   logic [DW-1:0] dly_q;
   logic [DW-1:0] dly_d;

   always_comb begin
      dly_d = dly_q;
      if (load) begin
         dly_d = x;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q <= '0;
      end else begin
         dly_q <= dly_d;
      end
   end

   // Wraps mod 2^DW by design; the CIC relies on it.
   assign y = x - dly_q;

endmodule

// File: rtl/ctdsm_cic_decimator.sv
// ctdsm_cic_decimator: sinc^2 CIC decimator (R = 2^RATE_LOG2) for a 1-bit
// delta-sigma bitstream. Ports: clk, rst (sync, active-high), en, bit_in,
// out_if (master: out_data, out_valid, out_ready, overrun).
// Build option CTDSM_DEC_OFFSET_EN: subtract R^2/2, two's complement output.
module ctdsm_cic_decimator
   import ctdsm_pkg::*;
#(
   parameter int RATE_LOG2 = CTDSM_RATE_LOG2_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic bit_in,
   ctdsm_cic_decimator_if.master out_if
);

   localparam int DW = ctdsm_dw(RATE_LOG2);

   logic [DW-1:0]        i1_q, i1_d;
   logic [DW-1:0]        i2_q, i2_d;
   logic [RATE_LOG2-1:0] cnt_q, cnt_d;
   logic                 dec_pend_q, dec_pend_d;
   logic [DW-1:0]        out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 overrun_q, overrun_d;

   logic [DW-1:0] c1;
   logic [DW-1:0] c2;
   logic [DW-1:0] sample;
   logic          accept;

   // Integrators and frame counter.
   always_comb begin
      i1_d       = i1_q;
      i2_d       = i2_q;
      cnt_d      = cnt_q;
      dec_pend_d = 1'b0;
      if (en) begin
         i1_d       = i1_q + {{(DW-1){1'b0}}, bit_in};
         i2_d       = i2_q + i1_q;
         cnt_d      = cnt_q + 1'b1;
         dec_pend_d = (cnt_q == {RATE_LOG2{1'b1}});
      end
   end

   // Combs fire one clock after the decimation edge, on registered I2.
   ctdsm_cic_comb #(.DW(DW)) u_comb1 (
      .clk  (clk),
      .rst  (rst),
      .load (dec_pend_q),
      .x    (i2_q),
      .y    (c1)
   );

   ctdsm_cic_comb #(.DW(DW)) u_comb2 (
      .clk  (clk),
      .rst  (rst),
      .load (dec_pend_q),
      .x    (c1),
      .y    (c2)
   );

`ifdef CTDSM_DEC_OFFSET_EN
   localparam logic [DW-1:0] OFFSET = DW'(ctdsm_offset(RATE_LOG2));
   assign sample = c2 - OFFSET;
`else
   assign sample = c2;
`endif

   assign accept = out_valid_q & out_if.out_ready;

   // One-deep output buffer; a load always wins, accept only clears.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;
      if (dec_pend_q) begin
         out_data_d  = sample;
         out_valid_d = 1'b1;
         if (out_valid_q && !out_if.out_ready) begin
            overrun_d = 1'b1;
         end
      end else if (accept) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i1_q        <= '0;
         i2_q        <= '0;
         cnt_q       <= '0;
         dec_pend_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         cnt_q       <= cnt_d;
         dec_pend_q  <= dec_pend_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.overrun   = overrun_q;

endmodule

// File: tb/tb_ctdsm_cic_decimator.sv
// tb_ctdsm_cic_decimator: directed table scenarios, handshake corner cases
// and a randomized run checked against a convolution-level reference.
module tb_ctdsm_cic_decimator;
   import ctdsm_pkg::*;

   localparam int RL = 5;
   localparam int R  = 1 << RL;
   localparam int DW = ctdsm_dw(RL);
`ifdef CTDSM_DEC_OFFSET_EN
   localparam int OFS = ctdsm_offset(RL);
`else
   localparam int OFS = 0;
`endif

   logic clk;
   logic rst;
   logic en;
   logic bit_in;

   ctdsm_cic_decimator_if #(.DW(DW)) out_if ();

   ctdsm_cic_decimator #(.RATE_LOG2(RL)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .bit_in (bit_in),
      .out_if (out_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;

   // Reference state: bit history since reset plus the buffer rules.
   bit            hist[$];
   bit            m_pend;
   logic [DW-1:0] m_pval;
   bit            m_vld;
   logic [DW-1:0] m_dat;
   bit            m_ovr;

   // Double-integrated value after n bits: sum of (n-1-k) * x[k].
   function automatic int i2_at(input int n);
      int s;
      s = 0;
      for (int k = 0; k < n; k++) s += (n - 1 - k) * int'(hist[k]);
      return s;
   endfunction

   function automatic logic [DW-1:0] cic_ref(input int n);
      int y;
      y = i2_at(n) - 2 * i2_at(n - R) + i2_at(n - 2 * R);
      return DW'(y - OFS);
   endfunction

   function automatic logic [DW-1:0] ex(input int raw);
      return DW'(raw - OFS);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input logic r, input logic e, input logic b,
                       input logic rdy);
      rst = r;
      en = e;
      bit_in = b;
      out_if.out_ready = rdy;
      @(posedge clk);
      if (r) begin
         hist.delete();
         m_pend = 0;
         m_vld = 0;
         m_dat = '0;
         m_ovr = 0;
      end else begin
         if (m_pend) begin
            if (m_vld && !rdy) m_ovr = 1;
            m_vld = 1;
            m_dat = m_pval;
         end else if (m_vld && rdy) begin
            m_vld = 0;
         end
         m_pend = 0;
         if (e) begin
            hist.push_back(b);
            if (hist.size() % R == 0) begin
               m_pend = 1;
               m_pval = cic_ref(hist.size());
            end
         end
      end
      #1;
   endtask

   task automatic feed(input int n, input logic rdy);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b1, rdy);
   endtask

   function automatic logic pat_bit(input int pat, input int k);
      if (pat == 0) return 1'b0;
      if (pat == 1) return 1'b1;
      return (k % 2) == 0;
   endfunction

   typedef struct {
      int pat;
      int per;
      int nfr;
      int first;
      int settled;
   } vec_t;

   vec_t vt[4];

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst = 1'b1;
      en = 1'b0;
      bit_in = 1'b0;
      out_if.out_ready = 1'b0;
      m_pend = 0;
      m_vld = 0;
      m_dat = '0;
      m_ovr = 0;
      m_pval = '0;

      vt[0] = '{pat: 1, per: 1, nfr: 5, first: 496, settled: 1024};
      vt[1] = '{pat: 2, per: 3, nfr: 4, first: 256, settled: 512};
      vt[2] = '{pat: 0, per: 1, nfr: 3, first: 0,   settled: 0};
      vt[3] = '{pat: 1, per: 2, nfr: 3, first: 496, settled: 1024};

      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_data", int'(out_if.out_data), 0);
      chk("rst_valid", int'(out_if.out_valid), 0);
      chk("rst_overrun", int'(out_if.overrun), 0);

      for (int s = 0; s < 4; s++) begin
         int k;
         int got;
         int last_t;
         int t;
         int budget;
         k = 0;
         got = 0;
         last_t = -1;
         t = 0;
         budget = R * vt[s].per * vt[s].nfr + 10;
         tick(1'b1, 1'b0, 1'b0, 1'b1);
         while (got < vt[s].nfr && t < budget) begin
            logic e;
            logic b;
            logic dp;
            e = (t % vt[s].per) == (vt[s].per - 1);
            b = pat_bit(vt[s].pat, k);
            dp = m_pend;
            tick(1'b0, e, b, 1'b1);
            if (e) k++;
            chk("valid_timing", int'(out_if.out_valid), int'(dp));
            if (out_if.out_valid) begin
               if (got == 0)
                  chk("first_out", int'(out_if.out_data),
                      int'(ex(vt[s].first)));
               else begin
                  chk("settled_out", int'(out_if.out_data),
                      int'(ex(vt[s].settled)));
                  chk("spacing", t - last_t, R * vt[s].per);
               end
               chk("no_overrun", int'(out_if.overrun), 0);
               last_t = t;
               got++;
            end
            t++;
         end
         chk("n_outputs", got, vt[s].nfr);
      end

      // Two loads with no consumer: overrun, newer data shown.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      feed(32, 1'b0);
      chk("ovr_pre_valid", int'(out_if.out_valid), 0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("ovr_first_valid", int'(out_if.out_valid), 1);
      chk("ovr_first_data", int'(out_if.out_data), int'(ex(496)));
      chk("ovr_first_flag", int'(out_if.overrun), 0);
      feed(31, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("ovr_second_data", int'(out_if.out_data), int'(ex(1024)));
      chk("ovr_set", int'(out_if.overrun), 1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      chk("ovr_accept_valid", int'(out_if.out_valid), 0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_sticky", int'(out_if.overrun), 1);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      chk("ovr_rst", int'(out_if.overrun), 0);

      // Accept on the same edge as a load.
      feed(32, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("same_pre_valid", int'(out_if.out_valid), 1);
      feed(31, 1'b0);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      chk("same_valid", int'(out_if.out_valid), 1);
      chk("same_data", int'(out_if.out_data), int'(ex(1024)));
      chk("same_no_ovr", int'(out_if.overrun), 0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      chk("hold_valid", int'(out_if.out_valid), 1);
      chk("hold_data", int'(out_if.out_data), int'(ex(1024)));

      // Reset at bit 20 of a frame with a sample waiting.
      feed(18, 1'b0);
      chk("mid_pre_valid", int'(out_if.out_valid), 1);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      chk("mid_rst_data", int'(out_if.out_data), 0);
      chk("mid_rst_valid", int'(out_if.out_valid), 0);
      chk("mid_rst_ovr", int'(out_if.overrun), 0);
      begin
         int early;
         early = 0;
         for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1);
            if (out_if.out_valid) early++;
         end
         chk("mid_no_early_out", early, 0);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_next_valid", int'(out_if.out_valid), 1);
      chk("mid_next_data", int'(out_if.out_data), int'(ex(496)));

      // Randomized traffic against the reference.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 4000; c++) begin
         logic r;
         logic e;
         logic b;
         logic rdy;
         r = ($urandom_range(0, 999) == 0);
         e = $urandom_range(0, 1) == 1;
         b = ($urandom_range(0, 99) < 70);
         rdy = ($urandom_range(0, 9) < 7);
         tick(r, e, b, rdy);
         chk("rand_state",
             int'({out_if.out_valid, out_if.overrun, out_if.out_data}),
             int'({m_vld, m_ovr, m_dat}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
